xseq_calc_alu: RTL and testbench

- Parametrised, memory-mapped signed ALU peripheral; successor to the fixed 4-bit calculator ALU.
- Sits on the controller data bus beside the register file, with a select decoded by the address decoder.
- ADD, SUB and NEG complete in one cycle. MUL (shift-add) and DIV (restoring) are multi-cycle.
- Reports busy, done, divide-by-zero and overflow through a status register and two outputs.

---
 rtl/xseq_calc_alu_pkg.sv | 36 +++
 rtl/xseq_muldiv.sv | 94 +++++++++
 rtl/xseq_calc_alu.sv | 242 ++++++++++++++++++++++++
 tb/tb_xseq_calc_alu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xseq_calc_alu_pkg.sv
// Shared definitions for the sequential calculator ALU: opcodes, register
// offsets, STATUS bit positions and FSM state encodings.
package xseq_calc_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_NEG = 3'd4
    } opcode_e;

    // Write offsets
    localparam logic [1:0] REG_OPA    = 2'd0;
    localparam logic [1:0] REG_OPB    = 2'd1;
    localparam logic [1:0] REG_CMD    = 2'd2;
    // Read offsets
    localparam logic [1:0] REG_RES_LO = 2'd0;
    localparam logic [1:0] REG_RES_HI = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_OPS    = 2'd3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DZ   = 2;
    localparam int ST_OVF  = 3;
    localparam int ST_REJ  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/xseq_muldiv.sv
// Iterative unsigned magnitude engine: shift-add multiplier or restoring
// divider, one bit per cycle. Outputs show the value after the current step.
module xseq_muldiv #(
    parameter int OPND_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,     // 0 = multiply, 1 = divide
    input  logic [OPND_W-1:0] a_mag_i,
    input  logic [OPND_W-1:0] b_mag_i,
    output logic              last_o,
    output logic [OPND_W-1:0] lo_o,       // product low half or quotient
    output logic [OPND_W-1:0] hi_o        // product high half or remainder
);

    logic              active_q, active_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OPND_W-1:0] lo_q, lo_d;
    logic [OPND_W-1:0] hi_q, hi_d;
    logic [OPND_W-1:0] b_q, b_d;

    logic [OPND_W:0]   mul_sum;
    logic [OPND_W:0]   div_shift;
    logic [OPND_W:0]   div_diff;
    logic              div_ge;
    logic [OPND_W-1:0] step_lo;
    logic [OPND_W-1:0] step_hi;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Partial remainder stays below the divisor, so the shifted value fits
        // in OPND_W+1 bits and the top bit of the difference is its sign.
        div_shift = {hi_q, lo_q[OPND_W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = !div_diff[OPND_W];
        if (mode_q) begin
            step_hi = div_ge ? div_diff[OPND_W-1:0] : div_shift[OPND_W-1:0];
            step_lo = {lo_q[OPND_W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[OPND_W:1];
            step_lo = {mul_sum[0], lo_q[OPND_W-1:1]};
        end
    end

    assign last_o = active_q && (cnt_q == CNT_W'(1));
    assign lo_o   = step_lo;
    assign hi_o   = step_hi;

    always_comb begin
        active_d = active_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        b_d      = b_q;
        if (start_i) begin
            active_d = 1'b1;
            mode_d   = mode_i;
            cnt_d    = CNT_W'(OPND_W);
            lo_d     = a_mag_i;
            hi_d     = '0;
            b_d      = b_mag_i;
        end else if (active_q) begin
            lo_d  = step_lo;
            hi_d  = step_hi;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
        end
    end

endmodule

// File: rtl/xseq_calc_alu.sv
// Memory-mapped signed ALU peripheral: bus decode, sign handling and flags.
// Define SEQ_CALC_SAT_EN to saturate ADD/SUB/NEG results on overflow.
module xseq_calc_alu
    import xseq_calc_alu_pkg::*;
#(
    parameter int OPND_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done
);

    localparam logic [OPND_W-1:0] MAX_V = {1'b0, {(OPND_W-1){1'b1}}};
    localparam logic [OPND_W-1:0] MIN_V = {1'b1, {(OPND_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [OPND_W-1:0] opa_q, opa_d;
    logic [OPND_W-1:0] opb_q, opb_d;
    logic [OPND_W-1:0] res_lo_q, res_lo_d;
    logic [OPND_W-1:0] res_hi_q, res_hi_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic              rej_q, rej_d;

    opcode_e op;
    logic    busy_w;
    logic    cmd_wr;
    logic    opa_wr;
    logic    opb_wr;
    logic    unused_data;

    assign op          = opcode_e'(data_in[2:0]);
    assign busy_w      = (state_q == S_MUL) || (state_q == S_DIV);
    assign cmd_wr      = sel && we && (addr == REG_CMD);
    assign opa_wr      = sel && we && (addr == REG_OPA) && !busy_w;
    assign opb_wr      = sel && we && (addr == REG_OPB) && !busy_w;
    assign unused_data = ^data_in;

    // Magnitude engine; MIN's magnitude is representable as an unsigned value.
    logic              md_start;
    logic              md_last;
    logic [OPND_W-1:0] md_lo;
    logic [OPND_W-1:0] md_hi;
    logic [OPND_W-1:0] a_mag;
    logic [OPND_W-1:0] b_mag;

    assign a_mag    = opa_q[OPND_W-1] ? -opa_q : opa_q;
    assign b_mag    = opb_q[OPND_W-1] ? -opb_q : opb_q;
    assign md_start = cmd_wr && (state_q == S_IDLE) &&
                      ((op == OP_MUL) || ((op == OP_DIV) && (opb_q != '0)));

    xseq_muldiv #(
        .OPND_W (OPND_W),
        .CNT_W  (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .mode_i  (op == OP_DIV),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .last_o  (md_last),
        .lo_o    (md_lo),
        .hi_o    (md_hi)
    );

    // Single-cycle datapath for ADD/SUB/NEG
    logic [OPND_W-1:0] fast_wrap;
    logic [OPND_W-1:0] fast_res;
    logic              fast_ovf;

    always_comb begin
        fast_wrap = '0;
        fast_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                fast_wrap = opa_q + opb_q;
                fast_ovf  = (opa_q[OPND_W-1] == opb_q[OPND_W-1]) &&
                            (fast_wrap[OPND_W-1] != opa_q[OPND_W-1]);
            end
            OP_SUB: begin
                fast_wrap = opa_q - opb_q;
                fast_ovf  = (opa_q[OPND_W-1] != opb_q[OPND_W-1]) &&
                            (fast_wrap[OPND_W-1] != opa_q[OPND_W-1]);
            end
            default: begin
                fast_wrap = -opa_q;
                fast_ovf  = (opa_q == MIN_V);
            end
        endcase
`ifdef SEQ_CALC_SAT_EN
        // A wrapped negative result means the true value overflowed upward.
        if (fast_ovf) begin
            fast_res = fast_wrap[OPND_W-1] ? MAX_V : MIN_V;
        end else begin
            fast_res = fast_wrap;
        end
`else
        fast_res = fast_wrap;
`endif
    end

    // Sign correction of the magnitude results
    logic                res_neg;
    logic [2*OPND_W-1:0] prod_mag;
    logic [2*OPND_W-1:0] prod_s;
    logic [OPND_W-1:0]   quo_s;
    logic [OPND_W-1:0]   rem_s;
    logic                div_ovf;

    assign res_neg  = opa_q[OPND_W-1] ^ opb_q[OPND_W-1];
    assign prod_mag = {md_hi, md_lo};
    assign prod_s   = res_neg ? -prod_mag : prod_mag;
    assign quo_s    = res_neg ? -md_lo : md_lo;
    assign rem_s    = opa_q[OPND_W-1] ? -md_hi : md_hi;
    assign div_ovf  = (opa_q == MIN_V) && (opb_q == '1);

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_wr ? data_in[OPND_W-1:0] : opa_q;
        opb_d    = opb_wr ? data_in[OPND_W-1:0] : opb_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        done_d   = done_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        rej_d    = rej_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_wr) begin
                    done_d = 1'b0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    rej_d  = 1'b0;
                    case (op)
                        OP_ADD, OP_SUB, OP_NEG: begin
                            res_lo_d = fast_res;
                            ovf_d    = fast_ovf;
                            state_d  = S_FIN;
                        end
                        OP_MUL: state_d = S_MUL;
                        OP_DIV: begin
                            if (opb_q == '0) begin
                                dz_d     = 1'b1;
                                res_lo_d = '1;
                                res_hi_d = opa_q;
                                state_d  = S_FIN;
                            end else begin
                                state_d = S_DIV;
                            end
                        end
                        default: begin
                            rej_d   = 1'b1;
                            state_d = S_FIN;
                        end
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cmd_wr) begin
                    rej_d = 1'b1;
                end
                if (md_last) begin
                    if (state_q == S_MUL) begin
                        res_lo_d = prod_s[OPND_W-1:0];
                        res_hi_d = prod_s[2*OPND_W-1:OPND_W];
                    end else begin
                        res_lo_d = quo_s;
                        res_hi_d = rem_s;
                        ovf_d    = div_ovf;
                    end
                    state_d = S_FIN;
                end
            end
            default: begin
                // Results are already written; a CMD here lands before done and is refused.
                if (cmd_wr) begin
                    rej_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            rej_q    <= rej_d;
        end
    end

    assign busy = busy_w;
    assign done = done_q;

    logic [4:0] status_bits;

    always_comb begin
        status_bits          = '0;
        status_bits[ST_BUSY] = busy_w;
        status_bits[ST_DONE] = done_q;
        status_bits[ST_DZ]   = dz_q;
        status_bits[ST_OVF]  = ovf_q;
        status_bits[ST_REJ]  = rej_q;
    end

    always_comb begin
        case (addr)
            REG_RES_LO: data_out = DATA_W'($signed(res_lo_q));
            REG_RES_HI: data_out = DATA_W'($signed(res_hi_q));
            REG_STATUS: data_out = DATA_W'(status_bits);
            default:    data_out = DATA_W'({opb_q, opa_q});
        endcase
    end

endmodule

// File: tb/tb_xseq_calc_alu.sv
// Directed-vector bench for xseq_calc_alu (OPND_W = 8, DATA_W = 32); expected
// values are hand-computed, SEQ_CALC_SAT_EN selects saturated expectations.
module tb_xseq_calc_alu;

    localparam logic [1:0] A_OPA = 2'd0, A_OPB = 2'd1, A_CMD = 2'd2, A_OPS = 2'd3;
    localparam logic [1:0] A_LO = 2'd0, A_HI = 2'd1, A_ST = 2'd2;
    localparam logic [31:0] C_ADD = 32'd0, C_SUB = 32'd1, C_MUL = 32'd2,
                            C_DIV = 32'd3, C_NEG = 32'd4, C_RSV = 32'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xseq_calc_alu #(
        .OPND_W (8),
        .DATA_W (32),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a;
        #1;
        check_eq(tag, data_out, exp);
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        bus_write(A_OPA, a);
        bus_write(A_OPB, b);
    endtask

    // Starts sampling 1ns after the CMD edge; counts edges until done and busy samples.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_cmd(input logic [31:0] op, output int cycles, output int busy_cycles);
        bus_write(A_CMD, op);
        wait_done(cycles, busy_cycles);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bcyc;
        int done_seen;

        rst = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        read_check("reset_res_lo", A_LO, 32'h0);
        read_check("reset_res_hi", A_HI, 32'h0);
        read_check("reset_status", A_ST, 32'h0);
        read_check("reset_ops", A_OPS, 32'h0);

        // ADD 100 + 27 = 127 (no overflow)
        set_ops(32'd100, 32'd27);
        read_check("ops_packed", A_OPS, 32'h0000_1B64);
        run_cmd(C_ADD, cyc, bcyc);
        check_eq("add_latency", cyc, 32'd1);
        read_check("add_res_lo", A_LO, 32'h0000_007F);
        read_check("add_status", A_ST, 32'h02);

        // ADD 100 + 28 overflows positive
        set_ops(32'd100, 32'd28);
        run_cmd(C_ADD, cyc, bcyc);
`ifdef SEQ_CALC_SAT_EN
        read_check("add_ovf_res_lo", A_LO, 32'h0000_007F);
`else
        read_check("add_ovf_res_lo", A_LO, 32'hFFFF_FF80);
`endif
        read_check("add_ovf_status", A_ST, 32'h0A);

        // SUB 5 - 9 = -4; SUB -128 - 1 overflows negative
        set_ops(32'd5, 32'd9);
        run_cmd(C_SUB, cyc, bcyc);
        check_eq("sub_latency", cyc, 32'd1);
        read_check("sub_res_lo", A_LO, 32'hFFFF_FFFC);
        read_check("sub_status", A_ST, 32'h02);
        set_ops(32'h80, 32'd1);
        run_cmd(C_SUB, cyc, bcyc);
`ifdef SEQ_CALC_SAT_EN
        read_check("sub_ovf_res_lo", A_LO, 32'hFFFF_FF80);
`else
        read_check("sub_ovf_res_lo", A_LO, 32'h0000_007F);
`endif
        read_check("sub_ovf_status", A_ST, 32'h0A);

        // NEG of MIN, then NEG of 5
        run_cmd(C_NEG, cyc, bcyc);
`ifdef SEQ_CALC_SAT_EN
        read_check("neg_min_res_lo", A_LO, 32'h0000_007F);
`else
        read_check("neg_min_res_lo", A_LO, 32'hFFFF_FF80);
`endif
        read_check("neg_min_status", A_ST, 32'h0A);
        set_ops(32'd5, 32'd0);
        run_cmd(C_NEG, cyc, bcyc);
        read_check("neg_res_lo", A_LO, 32'hFFFF_FFFB);
        read_check("neg_status", A_ST, 32'h02);

        // MUL -3 * 5 = -15
        set_ops(32'hFD, 32'd5);
        run_cmd(C_MUL, cyc, bcyc);
        check_eq("mul_latency", cyc, 32'd9);
        check_eq("mul_busy_cycles", bcyc, 32'd8);
        read_check("mul_res_lo", A_LO, 32'hFFFF_FFF1);
        read_check("mul_res_hi", A_HI, 32'hFFFF_FFFF);
        read_check("mul_status", A_ST, 32'h02);

        // MUL -128 * -128 = 0x4000, no overflow flag
        set_ops(32'h80, 32'h80);
        run_cmd(C_MUL, cyc, bcyc);
        read_check("mul_min_res_lo", A_LO, 32'h0000_0000);
        read_check("mul_min_res_hi", A_HI, 32'h0000_0040);
        read_check("mul_min_status", A_ST, 32'h02);

        // DIV -7 / 2 = -3 rem -1
        set_ops(32'hF9, 32'd2);
        run_cmd(C_DIV, cyc, bcyc);
        check_eq("div_latency", cyc, 32'd9);
        read_check("div_res_lo", A_LO, 32'hFFFF_FFFD);
        read_check("div_res_hi", A_HI, 32'hFFFF_FFFF);
        read_check("div_status", A_ST, 32'h02);

        // DIV 100 / 7 = 14 rem 2
        set_ops(32'd100, 32'd7);
        run_cmd(C_DIV, cyc, bcyc);
        read_check("div_pos_res_lo", A_LO, 32'h0000_000E);
        read_check("div_pos_res_hi", A_HI, 32'h0000_0002);

        // DIV MIN / -1 overflows
        set_ops(32'h80, 32'hFF);
        run_cmd(C_DIV, cyc, bcyc);
        read_check("div_ovf_res_lo", A_LO, 32'hFFFF_FF80);
        read_check("div_ovf_res_hi", A_HI, 32'h0000_0000);
        read_check("div_ovf_status", A_ST, 32'h0A);

        // DIV 5 / 0
        set_ops(32'd5, 32'd0);
        run_cmd(C_DIV, cyc, bcyc);
        check_eq("dz_latency", cyc, 32'd1);
        read_check("dz_res_lo", A_LO, 32'hFFFF_FFFF);
        read_check("dz_res_hi", A_HI, 32'h0000_0005);
        read_check("dz_status", A_ST, 32'h06);

        // Reserved opcode: results untouched, rej set
        run_cmd(C_RSV, cyc, bcyc);
        check_eq("rsv_latency", cyc, 32'd1);
        read_check("rsv_res_lo", A_LO, 32'hFFFF_FFFF);
        read_check("rsv_res_hi", A_HI, 32'h0000_0005);
        read_check("rsv_status", A_ST, 32'h12);

        // Back-to-back CMD right after done: accepted, done clears
        set_ops(32'd20, 32'd22);
        run_cmd(C_ADD, cyc, bcyc);
        bus_write(A_CMD, C_SUB);
        check_eq("b2b_done_cleared", {31'd0, done}, 32'd0);
        wait_done(cyc, bcyc);
        check_eq("b2b_latency", cyc, 32'd1);
        read_check("b2b_res_lo", A_LO, 32'hFFFF_FFFE);

        // MUL 10 * 10 with CMD and OPA write while busy
        set_ops(32'd10, 32'd10);
        bus_write(A_CMD, C_MUL);
        repeat (2) @(posedge clk);
        #1;
        bus_write(A_CMD, C_ADD);
        bus_write(A_OPA, 32'd99);
        read_check("rej_busy_status", A_ST, 32'h11);
        wait_done(cyc, bcyc);
        check_eq("rej_done", {31'd0, done}, 32'd1);
        read_check("rej_res_lo", A_LO, 32'h0000_0064);
        read_check("rej_res_hi", A_HI, 32'h0000_0000);
        read_check("rej_status", A_ST, 32'h12);
        read_check("rej_ops", A_OPS, 32'h0000_0A0A);

        // Reset in the middle of a DIV
        set_ops(32'h9C, 32'd3);
        bus_write(A_CMD, C_DIV);
        repeat (3) @(posedge clk);
        #1;
        check_eq("div_busy_pre_rst", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        read_check("rst_status", A_ST, 32'h0);
        read_check("rst_res_lo", A_LO, 32'h0);
        read_check("rst_res_hi", A_HI, 32'h0);
        read_check("rst_ops", A_OPS, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1;
        end
        check_eq("rst_no_done", done_seen, 32'd0);
        set_ops(32'd1, 32'd1);
        run_cmd(C_ADD, cyc, bcyc);
        check_eq("post_rst_latency", cyc, 32'd1);
        read_check("post_rst_res_lo", A_LO, 32'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
